// File: rtl/night_rider_trail_pwm.sv
// ---------------------------------------------------------------------------
// night_rider_trail_pwm
//
// Purpose:
//   Sits behind the night-rider LED scanner. It keeps a brightness level for
//   every LED. The LED under the scanner is set to full brightness, and every
//   other LED fades by a fixed amount each time the scanner steps. The levels
//   are then driven out through a frame-synchronous PWM. The result is a
//   fading "comet tail" behind the moving light.
//
// Parameters:
//   N        - number of LEDs (>= 2)
//   PWM_BITS - brightness / PWM counter width (2..8); full scale is 2^PWM_BITS-1
//   DECAY    - brightness removed from unlit LEDs on every step (1..full scale)
//
// Ports:
//   clk        - clock
//   rst_n      - asynchronous, active-low reset
//   led_in     - scanner position vector, normally one-hot, sampled on step
//   step       - one-cycle pulse, the scanner advanced this cycle
//   en         - PWM enable (level)
//   led_pwm    - registered PWM drive, one bit per LED
//   frame_sync - registered one-cycle pulse marking the first cycle of a frame
//   bright_out - live brightness levels, LED i at [i*PWM_BITS +: PWM_BITS]
// ---------------------------------------------------------------------------
module night_rider_trail_pwm #(
  parameter int N        = 8,
  parameter int PWM_BITS = 4,
  parameter int DECAY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          led_in,
  input  logic                  step,
  input  logic                  en,
  output logic [N-1:0]          led_pwm,
  output logic                  frame_sync,
  output logic [N*PWM_BITS-1:0] bright_out
);

  // Full-scale level, last counter value of a frame, and the decay amount,
  // all held at the brightness width so every compare is width-matched.
  localparam logic [PWM_BITS-1:0] MAX_LVL   = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LAST_CNT  = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] DECAY_LVL = PWM_BITS'(DECAY);

  // Per-LED brightness and shadow duty. They are packed so that bright_q
  // already has the flat layout bright_out needs.
  logic [N-1:0][PWM_BITS-1:0] bright_q;
  logic [N-1:0][PWM_BITS-1:0] bright_d;
  logic [N-1:0][PWM_BITS-1:0] shadow_q;
  logic [N-1:0][PWM_BITS-1:0] shadow_d;

  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] cnt_d;

  logic [N-1:0] led_pwm_q;
  logic [N-1:0] led_pwm_d;
  logic         frame_sync_q;
  logic         frame_sync_d;

  logic         shadowLoad;

  // Brightness update. Nothing changes unless the scanner stepped. On a step,
  // every LED flagged in led_in jumps to full scale. Several set bits are all
  // honoured. Every other LED loses DECAY and bottoms out at zero. The
  // compare happens before the subtraction, so the unsigned result never
  // wraps.
  always_comb begin
    bright_d = bright_q;
    if (step) begin
      for (int i = 0; i < N; i++) begin
        if (led_in[i]) begin
          bright_d[i] = MAX_LVL;
        end else if (bright_q[i] > DECAY_LVL) begin
          bright_d[i] = bright_q[i] - DECAY_LVL;
        end else begin
          bright_d[i] = '0;
        end
      end
    end
  end

  // Frame counter. It runs 0 .. MAX-1, so one frame is MAX cycles long and a
  // full-scale duty keeps the LED on for the whole frame. While disabled, the
  // counter is parked at 0. The first enabled cycle is therefore always the
  // start of a frame.
  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Shadow duty load. The shadow copies the brightness on exactly the edges
  // where the counter is about to be 0. A brightness change made mid-frame
  // therefore waits for the next frame boundary. A step landing on the load
  // edge is seen one frame late, because the load samples the old
  // brightness. While disabled, the shadow follows the brightness every
  // cycle, so the first enabled frame shows the current level.
  always_comb begin
    shadowLoad = !en || (cnt_q == LAST_CNT);
    shadow_d   = shadow_q;
    if (shadowLoad) begin
      shadow_d = bright_q;
    end
  end

  // PWM compare and frame marker. An LED is on while its duty is above the
  // counter, which gives s on-cycles at the start of every frame. The frame
  // marker is taken from the same counter value, so after the output register
  // it lines up with the led_pwm cycle for count 0.
  always_comb begin
    led_pwm_d = '0;
    for (int i = 0; i < N; i++) begin
      led_pwm_d[i] = en && (shadow_q[i] > cnt_q);
    end
    frame_sync_d = en && (cnt_q == '0);
  end

  // State registers. Reset clears every register immediately, including in
  // the middle of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bright_q     <= '0;
      shadow_q     <= '0;
      cnt_q        <= '0;
      led_pwm_q    <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      bright_q     <= bright_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      led_pwm_q    <= led_pwm_d;
      frame_sync_q <= frame_sync_d;
    end
  end

  assign led_pwm    = led_pwm_q;
  assign frame_sync = frame_sync_q;
  assign bright_out = bright_q;

endmodule

// File: tb/tb_night_rider_trail_pwm.sv
// ---------------------------------------------------------------------------
// tb_night_rider_trail_pwm
//
// Purpose:
//   Self-checking bench for night_rider_trail_pwm with N=8, PWM_BITS=4 and
//   DECAY=4. Directed scenarios check reset, decay, duty, mid-frame updates,
//   coincident shadow loads and enable gating against hand-derived values. A
//   randomized run is checked against a frame-level reference model kept
//   here.
// ---------------------------------------------------------------------------
module tb_night_rider_trail_pwm;

  localparam int N     = 8;
  localparam int PW    = 4;
  localparam int DECAY = 4;
  localparam int MAXV  = 15;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    led_in;
  logic            step;
  logic            en;
  logic [N-1:0]    led_pwm;
  logic            frame_sync;
  logic [N*PW-1:0] bright_out;

  int checks;
  int failures;

  night_rider_trail_pwm #(
    .N        (N),
    .PWM_BITS (PW),
    .DECAY    (DECAY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_in     (led_in),
    .step       (step),
    .en         (en),
    .led_pwm    (led_pwm),
    .frame_sync (frame_sync),
    .bright_out (bright_out)
  );

  // 10 ns clock. Inputs change and outputs are sampled on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model. Brightness and the latched frame duty are plain
  // integers. framePos is the position inside the current frame, counted in
  // cycles since the frame began. The expected outputs are registered the
  // same way as the real outputs.
  int           mb [N];
  int           ms [N];
  int           framePos;
  logic [N-1:0] mPwm;
  logic         mSync;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        mb[i] <= 0;
        ms[i] <= 0;
      end
      framePos <= 0;
      mPwm     <= '0;
      mSync    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        mPwm[i] <= en && (framePos < ms[i]);
        if (!en || framePos == MAXV - 1) ms[i] <= mb[i];
        if (step) mb[i] <= led_in[i] ? MAXV : ((mb[i] > DECAY) ? mb[i] - DECAY : 0);
      end
      mSync    <= en && (framePos == 0);
      framePos <= en ? (framePos + 1) % MAXV : 0;
    end
  end

  function automatic logic [N*PW-1:0] modelBright();
    logic [N*PW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*PW +: PW] = PW'(mb[i]);
    return v;
  endfunction

  // Advances to the next falling edge where frame_sync is high, within a
  // fixed cycle budget.
  task automatic waitFrameSync(input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (frame_sync === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL %s_sync_timeout: frame_sync not seen within 40 cycles (required 1)", tag);
    end
  endtask

  task automatic test_reset();
    int gap;
    en = 1'b1;
    @(negedge clk);
    step = 1'b1; led_in = 8'h10;
    @(negedge clk);
    step = 1'b0; led_in = '0;
    waitFrameSync("reset");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led_pwm !== '0) begin
      failures++;
      $display("[TB] FAIL reset_led_pwm: got %h required 00", led_pwm);
    end
    checks++;
    if (frame_sync !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_frame_sync: got %b required 0", frame_sync);
    end
    checks++;
    if (bright_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_bright: got %h required 0", bright_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_sync !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_first_sync: got %b required 1", frame_sync);
    end
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (frame_sync === 1'b1) begin
          gap = k;
          break;
        end
      end
      checks++;
      if (gap != 15) begin
        failures++;
        $display("[TB] FAIL reset_sync_period: got %0d cycles required 15", gap);
      end
    end
  endtask

  task automatic test_decay();
    int expB0 [4] = '{11, 7, 3, 0};
    @(negedge clk);
    step = 1'b1; led_in = 8'h01;
    @(negedge clk);
    checks++;
    if (bright_out[0 +: PW] !== 4'd15) begin
      failures++;
      $display("[TB] FAIL decay_b0_set: got %0d required 15", bright_out[0 +: PW]);
    end
    for (int k = 0; k < 4; k++) begin
      led_in = 8'h02;
      @(negedge clk);
      checks++;
      if (bright_out[0 +: PW] !== PW'(expB0[k])) begin
        failures++;
        $display("[TB] FAIL decay_b0_step%0d: got %0d required %0d", k, bright_out[0 +: PW], expB0[k]);
      end
      checks++;
      if (bright_out[PW +: PW] !== 4'd15) begin
        failures++;
        $display("[TB] FAIL decay_b1_step%0d: got %0d required 15", k, bright_out[PW +: PW]);
      end
      checks++;
      if (bright_out[N*PW-1:2*PW] !== '0) begin
        failures++;
        $display("[TB] FAIL decay_others_step%0d: got %h required 0", k, bright_out[N*PW-1:2*PW]);
      end
    end
    step = 1'b0; led_in = '0;
  endtask

  task automatic test_duty();
    int hi;
    @(negedge clk);
    step = 1'b1; led_in = 8'h03;
    @(negedge clk);
    led_in = 8'h02;
    @(negedge clk);
    @(negedge clk);
    step = 1'b0; led_in = '0;
    checks++;
    if (bright_out[0 +: PW] !== 4'd7) begin
      failures++;
      $display("[TB] FAIL duty_b0_level: got %0d required 7", bright_out[0 +: PW]);
    end
    waitFrameSync("duty");
    waitFrameSync("duty");
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (frame_sync !== 1'b1) begin
        failures++;
        $display("[TB] FAIL duty_frame%0d_sync: got %b required 1", f, frame_sync);
      end
      hi = 0;
      for (int k = 0; k < MAXV; k++) begin
        if (led_pwm[0] === 1'b1) hi++;
        checks++;
        if (led_pwm[0] !== (k < 7)) begin
          failures++;
          $display("[TB] FAIL duty_b7_cycle%0d: got %b required %b", k, led_pwm[0], (k < 7));
        end
        checks++;
        if (led_pwm[1] !== 1'b1) begin
          failures++;
          $display("[TB] FAIL duty_b15_cycle%0d: got %b required 1", k, led_pwm[1]);
        end
        checks++;
        if (led_pwm[2] !== 1'b0) begin
          failures++;
          $display("[TB] FAIL duty_b0_cycle%0d: got %b required 0", k, led_pwm[2]);
        end
        @(negedge clk);
      end
      checks++;
      if (hi != 7) begin
        failures++;
        $display("[TB] FAIL duty_high_count: got %0d required 7", hi);
      end
    end
  endtask

  task automatic test_mid_frame();
    bit seen;
    waitFrameSync("midframe");
    repeat (4) @(negedge clk);
    step = 1'b1; led_in = 8'h04;
    @(negedge clk);
    step = 1'b0; led_in = '0;
    checks++;
    if (bright_out[2*PW +: PW] !== 4'd15) begin
      failures++;
      $display("[TB] FAIL midframe_b2_now: got %0d required 15", bright_out[2*PW +: PW]);
    end
    checks++;
    if (bright_out[PW +: PW] !== 4'd11) begin
      failures++;
      $display("[TB] FAIL midframe_b1_decay: got %0d required 11", bright_out[PW +: PW]);
    end
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (frame_sync === 1'b1) begin
        seen = 1;
        break;
      end
      checks++;
      if (led_pwm[2] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midframe_old_duty: got %b required 0", led_pwm[2]);
      end
      @(negedge clk);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("[TB] FAIL midframe_sync_timeout: got none required frame_sync");
    end
    for (int k = 0; k < MAXV; k++) begin
      checks++;
      if (led_pwm[2] !== 1'b1) begin
        failures++;
        $display("[TB] FAIL midframe_new_duty_cycle%0d: got %b required 1", k, led_pwm[2]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_coincident();
    waitFrameSync("coincident");
    repeat (13) @(negedge clk);
    step = 1'b1; led_in = 8'h08;
    @(negedge clk);
    step = 1'b0; led_in = '0;
    checks++;
    if (bright_out[3*PW +: PW] !== 4'd15) begin
      failures++;
      $display("[TB] FAIL coincident_b3: got %0d required 15", bright_out[3*PW +: PW]);
    end
    waitFrameSync("coincident");
    for (int f = 0; f < 2; f++) begin
      checks++;
      if (frame_sync !== 1'b1) begin
        failures++;
        $display("[TB] FAIL coincident_frame%0d_sync: got %b required 1", f, frame_sync);
      end
      for (int k = 0; k < MAXV; k++) begin
        checks++;
        if (led_pwm[3] !== (f == 1)) begin
          failures++;
          $display("[TB] FAIL coincident_frame%0d_cycle%0d: got %b required %b", f, k, led_pwm[3], (f == 1));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_enable_gating();
    @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step   = (k == 5 || k == 15 || k == 25);
      led_in = '0;
      @(negedge clk);
      checks++;
      if (led_pwm !== '0 || frame_sync !== 1'b0) begin
        failures++;
        $display("[TB] FAIL gate_outputs_cycle%0d: got pwm=%h sync=%b required 00/0", k, led_pwm, frame_sync);
      end
      checks++;
      if (bright_out !== modelBright()) begin
        failures++;
        $display("[TB] FAIL gate_bright_cycle%0d: got %h required %h", k, bright_out, modelBright());
      end
    end
    step = 1'b0;
    en   = 1'b1;
    @(negedge clk);
    checks++;
    if (frame_sync !== 1'b1) begin
      failures++;
      $display("[TB] FAIL gate_first_sync: got %b required 1", frame_sync);
    end
    for (int k = 0; k < 2 * MAXV; k++) begin
      checks++;
      if (led_pwm !== mPwm || frame_sync !== mSync) begin
        failures++;
        $display("[TB] FAIL gate_resume_cycle%0d: got pwm=%h sync=%b required %h/%b", k, led_pwm, frame_sync, mPwm, mSync);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) led_in = N'($urandom);
      else led_in = N'(1) << $urandom_range(0, N - 1);
      if ($urandom_range(0, 24) == 0) en = ~en;
      @(negedge clk);
      checks++;
      if (led_pwm !== mPwm) begin
        failures++;
        $display("[TB] FAIL random_pwm_cycle%0d: got %h required %h", k, led_pwm, mPwm);
      end
      checks++;
      if (frame_sync !== mSync) begin
        failures++;
        $display("[TB] FAIL random_sync_cycle%0d: got %b required %b", k, frame_sync, mSync);
      end
      checks++;
      if (bright_out !== modelBright()) begin
        failures++;
        $display("[TB] FAIL random_bright_cycle%0d: got %h required %h", k, bright_out, modelBright());
      end
    end
    step = 1'b0; led_in = '0; en = 1'b1;
  endtask

  // Scenario sequence, followed by the summary line.
  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    step     = 1'b0;
    led_in   = '0;
    en       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_decay();
    test_duty();
    test_mid_frame();
    test_coincident();
    test_enable_gating();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/night_rider_trail_pwm.md
# night_rider_trail_pwm

Downstream stage of the night-rider LED scanner. It takes the scanner's one-hot position vector and a step pulse, and keeps a per-LED brightness level. The lit position is set to full brightness and every other LED decays towards off on each step. It drives each LED through a frame-synchronous PWM so the output shows a fading "comet tail" behind the moving light.

## Interface

- N, 8: number of LEDs; N ≥ 2.
- PWM_BITS, 4: brightness width; 2..8. MAX = 2^PWM_BITS − 1.
- DECAY, 4: brightness subtracted per step; 1..MAX.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- led_in  in  N  position vector from the scanner; normally one-hot; sampled only when step=1.
- step  in  1  one-cycle pulse; the scanner advanced this cycle.
- en  in  1  PWM enable; level.
- led_pwm  out  N  PWM-modulated LED drive, registered.
- frame_sync  out  1  high for one cycle at the start of each PWM frame, registered.
- bright_out  out  N*PWM_BITS  live brightness registers; LED i occupies bits [i*PWM_BITS +: PWM_BITS].

## Operation

- Brightness b[i] (PWM_BITS wide) updates only on cycles with step=1:
  - led_in[i]=1: b[i] ← MAX.
  - led_in[i]=0: b[i] ← b[i] − DECAY if b[i] > DECAY, else 0. Subtraction saturates at 0 and never wraps.
  - More than one bit set in led_in: each set bit independently goes to MAX. There is no error check.
  - step=0: b holds, and led_in is ignored.
- PWM counter cnt (PWM_BITS wide):
  - en=1: counts 0 … MAX−1 and wraps to 0. The period is MAX cycles.
  - en=0: forced to 0.
- Shadow duty register s[i]:
  - Loads s[i] ← b[i] at every edge where the next cnt is 0, i.e. cnt==MAX−1 with en=1, or en=0.
  - Otherwise s holds. Brightness changes therefore never take effect mid-frame.
  - If step and a shadow load occur on the same edge, s takes the pre-update b. The new b appears one frame later.
- led_pwm[i] ← en & (s[i] > cnt), registered.
  - s=MAX gives always on while en=1; s=0 gives always off.
  - Duty is s[i]/MAX.
- frame_sync ← en & (cnt==0), registered, so it aligns with the led_pwm cycle that reflects cnt=0.
- Steps are processed regardless of en. bright_out reflects b at all times.

## Timing

- Reset (asynchronous, any cycle, including mid-frame): b, s, cnt, led_pwm and frame_sync all go to 0. First edge after release: cnt=0 → first frame_sync one cycle later if en=1.
- step at cycle t: bright_out shows the new value after the edge ending cycle t (latency 1).
- PWM output latency: led_pwm and frame_sync lag cnt by 1 cycle.
- Frame boundary: with en held high, frame_sync pulses every MAX cycles. In each frame, led_pwm[i] is high for the first s[i] cycles starting at the frame_sync cycle, then low for the remaining MAX − s[i] cycles.
- en 1→0: led_pwm and frame_sync go to 0 one cycle later. cnt resets and s tracks b continuously.
- en 0→1: the first frame_sync occurs one cycle after the first edge with en=1. That frame uses s = b as of that edge.

## Test plan

- Reset: assert rst_n=0 mid-frame with non-zero brightness → led_pwm=0, frame_sync=0, bright_out=0 immediately. After release with en=1, frame_sync repeats every 15 cycles (N=8, PWM_BITS=4, DECAY=4 throughout).
- Decay: step with led_in=0x01, then four steps with led_in=0x02 → b0 sequence 15, 11, 7, 3, 0; b1 = 15 after each of its steps; all other LEDs stay 0.
- Duty: b0=7 held steady → led_pwm[0] is high on the frame_sync cycle plus the following 6 cycles, then low for 8 cycles, in every frame. b=15 → constantly high; b=0 → constantly low.
- Mid-frame update: step sets b2=15 at cnt=5 → bright_out changes at once. led_pwm[2] stays at the old duty until the next frame_sync, then is high for the whole 15-cycle frame.
- Step coincident with shadow load: step at a cycle with cnt=14 → the next frame uses the old b and the following frame uses the new b.
- Enable gating: en=0 for 40 cycles with 3 steps → led_pwm and frame_sync stay 0 while bright_out decays correctly. After en=1, frame_sync arrives one cycle after the first enabled edge, and duty matches the current b.
